// File: rtl/xor_checksum.sv
// Streaming XOR checksum engine.
// Folds a framed stream of WIDTH-bit words into a running bitwise XOR.
// It then presents the checksum and the saturating beat count of each
// completed frame over a valid/ready result handshake.
// Optional feature: define XOR_CHECKSUM_PARITY_EN to add the registered
// OUT_PARITY output, which is the XOR-reduction of OUT_SUM.
module xor_checksum #(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [WIDTH-1:0]       IN_DATA,
    input  logic                   IN_VALID,
    input  logic                   IN_LAST,
    output logic                   IN_READY,
    input  logic                   ABORT,
    output logic [WIDTH-1:0]       OUT_SUM,
    output logic [COUNT_WIDTH-1:0] OUT_COUNT,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY
`ifdef XOR_CHECKSUM_PARITY_EN
    ,
    output logic                   OUT_PARITY
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no frame open
        S_ACCUM = 2'd1,   // frame open, accumulating
        S_HOLD  = 2'd2    // result presented, waiting for consumer
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]       sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   valid_q, valid_d;

    logic                   beat;
    logic [WIDTH-1:0]       acc_fold;
    logic [COUNT_WIDTH-1:0] cnt_fold;

    // Input is accepted in IDLE and ACCUM only; decoded from the registered
    // state so there is no path from OUT_READY to IN_READY.
    assign IN_READY = (state_q != S_HOLD) & ~RESET;
    assign beat     = IN_VALID & IN_READY;

    // Value the accumulator and counter take if the current beat is accepted:
    // the first beat of a frame restarts them, later beats fold in.
    always_comb begin
        if (state_q == S_ACCUM) begin
            acc_fold = acc_q ^ IN_DATA;
            cnt_fold = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
            acc_fold = IN_DATA;
            cnt_fold = CNT_ONE;
        end
    end

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold it.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        count_d = count_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (ABORT) begin
                    // Abort wins over a simultaneous beat; results untouched.
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (beat) begin
                    acc_d = acc_fold;
                    cnt_d = cnt_fold;
                    if (IN_LAST) begin
                        state_d = S_HOLD;
                        sum_d   = acc_fold;
                        count_d = cnt_fold;
                        valid_d = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from the values sampled before the edge.
        if (RESET) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign OUT_SUM   = sum_q;
    assign OUT_COUNT = count_q;
    assign OUT_VALID = valid_q;

`ifdef XOR_CHECKSUM_PARITY_EN
    logic parity_q;

    // Parity register tracks the checksum register, so it changes on the same edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^sum_d;
        end
    end

    assign OUT_PARITY = parity_q;
`endif

endmodule

// File: tb/tb_xor_checksum.sv
// Self-checking bench for xor_checksum.
// Two instances share one input stream: COUNT_WIDTH=8 and COUNT_WIDTH=2.
// The second instance exercises counter saturation. Expected results come
// from a frame-level model: XOR-fold of the frame's words, with the beat
// count clipped to the counter maximum.
module tb_xor_checksum;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          in_ready_s;
    logic          abort;
    logic [W-1:0]  out_sum;
    logic [W-1:0]  out_sum_s;
    logic [7:0]    out_count;
    logic [1:0]    out_count_s;
    logic          out_valid;
    logic          out_valid_s;
    logic          out_ready;
`ifdef XOR_CHECKSUM_PARITY_EN
    logic          out_parity;
    logic          out_parity_s;
`endif

    always #5 clk = ~clk;

    xor_checksum #(.WIDTH(W), .COUNT_WIDTH(8)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_LAST   (in_last),
        .IN_READY  (in_ready),
        .ABORT     (abort),
        .OUT_SUM   (out_sum),
        .OUT_COUNT (out_count),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
`ifdef XOR_CHECKSUM_PARITY_EN
        ,
        .OUT_PARITY(out_parity)
`endif
    );

    xor_checksum #(.WIDTH(W), .COUNT_WIDTH(2)) dut_s (
        .CLK       (clk),
        .RESET     (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_LAST   (in_last),
        .IN_READY  (in_ready_s),
        .ABORT     (abort),
        .OUT_SUM   (out_sum_s),
        .OUT_COUNT (out_count_s),
        .OUT_VALID (out_valid_s),
        .OUT_READY (out_ready)
`ifdef XOR_CHECKSUM_PARITY_EN
        ,
        .OUT_PARITY(out_parity_s)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [W-1:0] frame_q[$];
    logic [W-1:0] exp_sum  = '0;
    int           exp_len  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one beat; it is accepted at the next rising edge.
    task automatic drive_beat(input logic [W-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check("beat_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send frame_q, optionally with random idle cycles carrying a stray IN_LAST.
    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
                in_last  = 1'b0;
                check("gap_no_result", 32'(out_valid), 32'd0);
            end
            drive_beat(frame_q[i], (i == frame_q.size() - 1) ? 1'b1 : 1'b0);
        end
    endtask

    // Frame-level model result, checked one cycle after the last beat.
    task automatic expect_result();
        exp_sum = '0;
        foreach (frame_q[i]) exp_sum = exp_sum ^ frame_q[i];
        exp_len = frame_q.size();
        check("res_valid",   32'(out_valid),   32'd1);
        check("res_sum",     32'(out_sum),     32'(exp_sum));
        check("res_count",   32'(out_count),   32'((exp_len > 255) ? 255 : exp_len));
        check("res_count_s", 32'(out_count_s), 32'((exp_len > 3) ? 3 : exp_len));
        check("res_in_ready_low", 32'(in_ready), 32'd0);
`ifdef XOR_CHECKSUM_PARITY_EN
        check("res_parity",  32'(out_parity),  32'($countones(exp_sum) % 2));
`endif
    endtask

    // Hold the result for some cycles (optionally hammering the input), then consume it.
    task automatic release_result(input int hold_cycles, input bit hammer);
        out_ready = 1'b0;
        if (hammer) begin
            in_valid = 1'b1;
            in_data  = 16'hDEAD;
            in_last  = 1'b1;
        end
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum",   32'(out_sum),   32'(exp_sum));
            check("hold_ready", 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("hs_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_valid_low", 32'(out_valid), 32'd0);
        check("rel_ready_high", 32'(in_ready), 32'd1);
        check("rel_sum_kept",  32'(out_sum),   32'(exp_sum));
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready),  32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_sum",      32'(out_sum),   32'd0);
        check("rst_count",    32'(out_count), 32'd0);
`ifdef XOR_CHECKSUM_PARITY_EN
        check("rst_parity",   32'(out_parity), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Basic three-beat frame.
        frame_q = '{16'h00FF, 16'h0F0F, 16'hFFFF};
        send_frame(1'b0);
        expect_result();
        check("basic_sum_const", 32'(out_sum), 32'h0000F00F);
        release_result(0, 1'b0);

        // Single-beat frame from IDLE.
        frame_q = '{16'h1234};
        send_frame(1'b0);
        expect_result();
        release_result(0, 1'b0);

        // Backpressure with input hammering during HOLD.
        frame_q = '{16'hAAAA, 16'h5555};
        send_frame(1'b0);
        expect_result();
        check("bp_sum_const", 32'(out_sum), 32'h0000FFFF);
        release_result(5, 1'b1);

        // Abort with simultaneous beat, after a stray IN_LAST without valid.
        drive_beat(16'h1111, 1'b0);
        drive_beat(16'h2222, 1'b0);
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        check("stray_last_no_result", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h4444;
        abort    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_no_result", 32'(out_valid), 32'd0);
        check("abort_sum_kept",  32'(out_sum),   32'h0000FFFF);
        check("abort_ready",     32'(in_ready),  32'd1);
        frame_q = '{16'h0001};
        send_frame(1'b0);
        expect_result();
        release_result(0, 1'b0);

        // Counter saturation on the narrow-counter instance.
        frame_q = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        send_frame(1'b0);
        expect_result();
        check("sat_count_const", 32'(out_count_s), 32'd3);
        release_result(1, 1'b0);

        // Asynchronous reset in the middle of a frame.
        drive_beat(16'h0F00, 1'b0);
        drive_beat(16'h00F0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_sum",     32'(out_sum),     32'd0);
        check("mid_rst_count",   32'(out_count),   32'd0);
        check("mid_rst_count_s", 32'(out_count_s), 32'd0);
        check("mid_rst_valid",   32'(out_valid),   32'd0);
        check("mid_rst_ready",   32'(in_ready),    32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_rst_ready", 32'(in_ready),  32'd1);
        check("after_rst_valid", 32'(out_valid), 32'd0);
        frame_q = '{16'h00F0};
        send_frame(1'b0);
        expect_result();
        release_result(0, 1'b0);

        // Randomized frames with gaps, backpressure and occasional aborts.
        for (int f = 0; f < 30; f++) begin
            if (f % 5 == 4) begin
                drive_beat(16'($urandom), 1'b0);
                drive_beat(16'($urandom), 1'b0);
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check("rand_abort_no_result", 32'(out_valid), 32'd0);
            end
            frame_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) frame_q.push_back(16'($urandom));
            send_frame(1'b1);
            expect_result();
            release_result(int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
